// File: rtl/aes_block_sequencer.sv
// rtl/aes_block_sequencer.sv - APB-programmed multi-block AES sequencer (ECB/CBC) driving an external AesCore
//
// Purpose:
//   Holds the key, the IV and DEPTH 128-bit input/output block buffers behind an APB register map.
//   A start write streams LEN/16 blocks through an external AesCore one at a time. The chaining
//   value is XORed in when CBC is selected. Each result lands in the output buffer. Completion or
//   a rejected length raises a pending bit, which drives the maskable level interrupt.
//
// Ports:
//   iClk, iRsn                      clock, asynchronous active-low reset
//   iPsel/iPenable/iPwrite          APB control (no wait states)
//   iPaddr[15:0], iPwdata[31:0]     APB byte address / write data
//   oPrdata[31:0]                   APB read data, captured in the setup phase
//   oInt                            level interrupt = master & |(PEND & INT_EN)
//   oStAes                          one-cycle start pulse to AesCore
//   oAesKey[127:0]                  key register, driven continuously
//   oPlainText[127:0]               block to AesCore, stable from oStAes until iAesDone
//   iAesDone, iCpText[127:0]        AesCore done pulse and ciphertext

module aes_block_sequencer #(
  parameter int DEPTH  = 8,
  parameter bit CBC_EN = 1'b1
) (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iPsel,
  input  logic         iPenable,
  input  logic         iPwrite,
  input  logic [15:0]  iPaddr,
  input  logic [31:0]  iPwdata,
  output logic [31:0]  oPrdata,
  output logic         oInt,
  output logic         oStAes,
  output logic [127:0] oAesKey,
  output logic [127:0] oPlainText,
  input  logic         iAesDone,
  input  logic [127:0] iCpText
);

  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = AW + 1;
  localparam int WORDS = 4 * DEPTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } stateT;

  stateT stateQ, stateNext;

  logic [127:0] keyReg;
  logic [127:0] ivReg;
  logic [127:0] plainReg;
  logic [127:0] inBuf  [DEPTH];
  logic [127:0] outBuf [DEPTH];
  logic         ctrlCbc;
  logic [15:0]  lenReg;
  logic         lenErr;
  logic [5:0]   blocksDone;
  logic [AW-1:0] idx;
  logic [IW-1:0] nBlocks;
  logic [1:0]   intEn;
  logic [1:0]   pend;
  logic         masterEn;
  logic [31:0]  prdataReg;
  logic [31:0]  rdData;

  // Byte 0 of a 128-bit value is its MSB byte but the LSB byte of word 0, so
  // each 32-bit word is a byte-reversed slice of the vector.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  function automatic logic [31:0] getWord(input logic [127:0] v, input logic [1:0] k);
    logic [31:0] seg;
    case (k)
      2'd0:    seg = v[127:96];
      2'd1:    seg = v[95:64];
      2'd2:    seg = v[63:32];
      default: seg = v[31:0];
    endcase
    return bswap32(seg);
  endfunction

  function automatic logic [127:0] setWord(input logic [127:0] v, input logic [1:0] k,
                                           input logic [31:0] w);
    logic [127:0] r;
    r = v;
    case (k)
      2'd0:    r[127:96] = bswap32(w);
      2'd1:    r[95:64]  = bswap32(w);
      2'd2:    r[63:32]  = bswap32(w);
      default: r[31:0]   = bswap32(w);
    endcase
    return r;
  endfunction

  // APB phase qualifiers and address decode
  logic       apbWr;
  logic       apbRdSetup;
  logic       aligned;
  logic [9:0] wordIdx;
  logic [AW-1:0] bufBlk;
  logic [1:0] bufWord;
  logic       bufHit;
  logic       isCtrl, isLen, isStatus, isKey, isIv, isIn, isOut, isIntEn, isPend, isMaster;

  assign apbWr      = iPsel & iPenable & iPwrite;
  assign apbRdSetup = iPsel & ~iPenable & ~iPwrite;
  assign aligned    = (iPaddr[1:0] == 2'b00);
  assign wordIdx    = iPaddr[11:2];
  assign bufBlk     = wordIdx[AW+1:2];
  assign bufWord    = wordIdx[1:0];
  assign bufHit     = ({22'd0, wordIdx} < 32'(WORDS));

  assign isCtrl   = (iPaddr == 16'h0000);
  assign isLen    = (iPaddr == 16'h0004);
  assign isStatus = (iPaddr == 16'h0008);
  assign isKey    = aligned && (iPaddr[15:4] == 12'h400);
  assign isIv     = aligned && (iPaddr[15:4] == 12'h401);
  assign isIn     = aligned && (iPaddr[15:12] == 4'h5) && bufHit;
  assign isOut    = aligned && (iPaddr[15:12] == 4'h6) && bufHit;
  assign isIntEn  = (iPaddr == 16'hA000);
  assign isPend   = (iPaddr == 16'hA004);
  assign isMaster = (iPaddr == 16'hA008);

  // Sequencing control
  logic busy;
  logic lenOk;
  logic startReq, startGo, startBad;
  logic cbcWrVal;
  logic lastBlock;
  logic aesAccept;
  logic stAes;
  logic setDone;
  logic [1:0] pendSet, pendClr;

  // DONE still counts as busy so a start landing in that cycle is dropped
  // rather than racing the return to IDLE.
  assign busy      = (stateQ != IDLE);
  assign lenOk     = (lenReg != 16'd0) && (lenReg[3:0] == 4'd0) && (lenReg <= 16'(16 * DEPTH));
  assign startReq  = apbWr & isCtrl & iPwdata[0] & ~busy;
  assign startGo   = startReq & lenOk;
  assign startBad  = startReq & ~lenOk;
  assign cbcWrVal  = iPwdata[1] & CBC_EN;
  assign lastBlock = ({1'b0, idx} == (nBlocks - IW'(1)));
  assign aesAccept = (stateQ == WAIT) & iAesDone;

  assign pendSet = {startBad, setDone};
  assign pendClr = (apbWr && isPend) ? iPwdata[1:0] : 2'b00;

  // FSM state register
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  // FSM next state and control outputs
  always_comb begin
    stateNext = stateQ;
    stAes     = 1'b0;
    setDone   = 1'b0;
    case (stateQ)
      IDLE: begin
        if (startGo) stateNext = LOAD;
      end
      LOAD: begin
        stAes     = 1'b1;
        stateNext = WAIT;
      end
      WAIT: begin
        if (iAesDone) stateNext = lastBlock ? DONE : LOAD;
      end
      DONE: begin
        setDone   = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Register file, buffers and datapath
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      keyReg     <= '0;
      ivReg      <= '0;
      plainReg   <= '0;
      ctrlCbc    <= 1'b0;
      lenReg     <= '0;
      lenErr     <= 1'b0;
      blocksDone <= '0;
      idx        <= '0;
      nBlocks    <= '0;
      intEn      <= '0;
      pend       <= '0;
      masterEn   <= 1'b0;
      prdataReg  <= '0;
      for (int b = 0; b < DEPTH; b++) begin
        inBuf[b]  <= '0;
        outBuf[b] <= '0;
      end
    end else begin
      // Configuration and data writes are frozen while a run is in flight
      if (apbWr && !busy) begin
        if (isCtrl) ctrlCbc <= cbcWrVal;
        if (isLen)  lenReg  <= iPwdata[15:0];
        if (isKey)  keyReg  <= setWord(keyReg, iPaddr[3:2], iPwdata);
        if (isIv)   ivReg   <= setWord(ivReg, iPaddr[3:2], iPwdata);
        if (isIn)   inBuf[bufBlk] <= setWord(inBuf[bufBlk], bufWord, iPwdata);
      end
      if (apbWr && isIntEn)  intEn    <= iPwdata[1:0];
      if (apbWr && isMaster) masterEn <= iPwdata[0];

      // A set in the same cycle as a W1C of that bit wins
      pend <= (pend & ~pendClr) | pendSet;

      if (startBad) lenErr <= 1'b1;

      if (startGo) begin
        lenErr     <= 1'b0;
        blocksDone <= '0;
        idx        <= '0;
        nBlocks    <= lenReg[AW+4:4];
        // The start write also sets the mode, so the first block uses the
        // written cbc bit; the IV is the first chaining value.
        plainReg   <= inBuf[0] ^ (cbcWrVal ? ivReg : 128'd0);
      end

      if (aesAccept) begin
        outBuf[idx] <= iCpText;
        blocksDone  <= blocksDone + 6'd1;
        if (!lastBlock) begin
          idx      <= idx + AW'(1);
          // The fresh ciphertext is the chaining value for the next block
          plainReg <= inBuf[idx + AW'(1)] ^ (ctrlCbc ? iCpText : 128'd0);
        end
      end

      if (apbRdSetup) prdataReg <= rdData;
    end
  end

  // Read mux, captured into prdataReg during the setup phase
  always_comb begin
    rdData = '0;
    if (isCtrl)        rdData = {30'd0, ctrlCbc, 1'b0};
    else if (isLen)    rdData = {16'd0, lenReg};
    else if (isStatus) rdData = {24'd0, blocksDone, lenErr, busy};
    else if (isKey)    rdData = getWord(keyReg, iPaddr[3:2]);
    else if (isIv)     rdData = getWord(ivReg, iPaddr[3:2]);
    else if (isIn)     rdData = getWord(inBuf[bufBlk], bufWord);
    else if (isOut)    rdData = getWord(outBuf[bufBlk], bufWord);
    else if (isIntEn)  rdData = {30'd0, intEn};
    else if (isPend)   rdData = {30'd0, pend};
    else if (isMaster) rdData = {31'd0, masterEn};
  end

  assign oPrdata    = prdataReg;
  assign oInt       = masterEn & |(pend & intEn);
  assign oStAes     = stAes;
  assign oAesKey    = keyReg;
  assign oPlainText = plainReg;

endmodule
